// File: rtl/decode_stage_pkg.sv
// Shared pa-upc decode definitions: opcodes, control-flag bit positions and
// instruction field positions, used by decode, execute and hazard logic.
package decode_stage_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned OPC_W   = 7;
    localparam int unsigned FLAG_W  = 5;

    localparam logic [OPC_W-1:0] OP_ADD  = 7'h00;
    localparam logic [OPC_W-1:0] OP_SUB  = 7'h01;
    localparam logic [OPC_W-1:0] OP_MUL  = 7'h02;
    localparam logic [OPC_W-1:0] OP_LDB  = 7'h10;
    localparam logic [OPC_W-1:0] OP_LDW  = 7'h11;
    localparam logic [OPC_W-1:0] OP_STB  = 7'h12;
    localparam logic [OPC_W-1:0] OP_STW  = 7'h13;
    localparam logic [OPC_W-1:0] OP_BEQ  = 7'h30;
    localparam logic [OPC_W-1:0] OP_JUMP = 7'h31;

    // Positions within the {mem_read, mem_write, mem_byte, reg_write, mem_to_reg} vector
    localparam int unsigned FLAG_MEM_READ  = 4;
    localparam int unsigned FLAG_MEM_WRITE = 3;
    localparam int unsigned FLAG_MEM_BYTE  = 2;
    localparam int unsigned FLAG_REG_WRITE = 1;
    localparam int unsigned FLAG_MEM_TO_REG = 0;

    localparam int unsigned OPC_LSB     = 25;
    localparam int unsigned DST_LSB     = 20;
    localparam int unsigned SRC1_LSB    = 15;
    localparam int unsigned SRC2_LSB    = 10;
    localparam int unsigned MOFF_MSB    = 14;
    localparam int unsigned BOFF_LO_MSB = 9;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JUMP
    } instr_class_e;

    function automatic instr_class_e classify(input logic [OPC_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL: return CLS_ALU;
            OP_LDB, OP_LDW:         return CLS_LOAD;
            OP_STB, OP_STW:         return CLS_STORE;
            OP_BEQ:                 return CLS_BRANCH;
            OP_JUMP:                return CLS_JUMP;
            default:                return CLS_NOP;
        endcase
    endfunction

    function automatic logic [FLAG_W-1:0] class_flags(input logic [OPC_W-1:0] op);
        logic [FLAG_W-1:0] f;
        f = '0;
        case (classify(op))
            CLS_ALU: f[FLAG_REG_WRITE] = 1'b1;
            CLS_LOAD: begin
                f[FLAG_MEM_READ]   = 1'b1;
                f[FLAG_REG_WRITE]  = 1'b1;
                f[FLAG_MEM_TO_REG] = 1'b1;
                f[FLAG_MEM_BYTE]   = (op == OP_LDB);
            end
            CLS_STORE: begin
                f[FLAG_MEM_WRITE] = 1'b1;
                f[FLAG_MEM_BYTE]  = (op == OP_STB);
            end
            default: f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/decode_stage_load_scoreboard.sv
// Load-use scoreboard: tracks load destinations for LOAD_LAT cycles after issue
// and flags when either enabled source register matches a busy entry.
module load_scoreboard
    import decode_stage_pkg::*;
#(
    parameter int unsigned LOAD_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load_issue,
    input  logic [REG_W-1:0] i_load_dst,
    input  logic             i_src1_en,
    input  logic [REG_W-1:0] i_src1,
    input  logic             i_src2_en,
    input  logic [REG_W-1:0] i_src2,
    output logic             o_hit
);

    logic [LOAD_LAT-1:0] r_valid;
    logic [REG_W-1:0]    r_reg [LOAD_LAT];
    logic                w_push;
    logic                w_src1_chk;
    logic                w_src2_chk;

    // r0 is never a real destination, so it is never tracked
    assign w_push     = i_load_issue & (i_load_dst != '0);
    assign w_src1_chk = i_src1_en & (i_src1 != '0);
    assign w_src2_chk = i_src2_en & (i_src2 != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            for (int unsigned i = 0; i < LOAD_LAT; i++) begin
                r_reg[i] <= '0;
            end
        end else begin
            r_valid[0] <= w_push;
            r_reg[0]   <= w_push ? i_load_dst : '0;
            for (int unsigned i = 1; i < LOAD_LAT; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_reg[i]   <= r_reg[i-1];
            end
        end
    end

    always_comb begin
        o_hit = 1'b0;
        for (int unsigned i = 0; i < LOAD_LAT; i++) begin
            if (r_valid[i] && ((w_src1_chk && (r_reg[i] == i_src1)) ||
                               (w_src2_chk && (r_reg[i] == i_src2)))) begin
                o_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decode_stage.sv
// pa-upc decode stage: one valid/ready instruction slot, combinational decode of
// the held instruction, load-use stall via load_scoreboard and a hazard counter.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    input  logic [XLEN-1:0]    in_pc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [6:0]         out_opcode,
    output logic [4:0]         out_dst_reg,
    output logic [4:0]         out_src_reg_1,
    output logic [4:0]         out_src_reg_2,
    output logic [XLEN-1:0]    out_mem_offset,
    output logic [XLEN-1:0]    out_brn_offset,
    output logic [19:0]        out_jmp_offset,
    output logic               out_alu_imm_src,
    output logic               out_mem_read,
    output logic               out_mem_write,
    output logic               out_mem_byte,
    output logic               out_reg_write,
    output logic               out_mem_to_reg,
    output logic               out_branch,
    output logic               out_jump,
    output logic               stall_hazard,
    output logic [CNT_W-1:0]   hazard_cycles
);

    logic                r_hold_valid;
    logic [INSTR_W-1:0]  r_hold_instr;
    logic [XLEN-1:0]     r_hold_pc;
    logic [CNT_W-1:0]    r_hazard_cycles;

    logic [OPC_W-1:0]    w_opcode;
    instr_class_e        w_class;
    logic [FLAG_W-1:0]   w_flags;
    logic                w_src1_en;
    logic                w_src2_en;
    logic                w_hit;
    logic                w_issue;
    logic                w_capture;
    logic                w_load_issue;
    logic [14:0]         w_brn_raw;

    assign w_opcode = r_hold_instr[OPC_LSB +: OPC_W];
    assign w_class  = classify(w_opcode);
    assign w_flags  = class_flags(w_opcode);

    always_comb begin
        w_src1_en = 1'b0;
        w_src2_en = 1'b0;
        case (w_class)
            CLS_ALU, CLS_STORE, CLS_BRANCH: begin
                w_src1_en = 1'b1;
                w_src2_en = 1'b1;
            end
            CLS_LOAD: w_src1_en = 1'b1;
            default: begin
                w_src1_en = 1'b0;
                w_src2_en = 1'b0;
            end
        endcase
    end

    assign stall_hazard = r_hold_valid & w_hit;
    assign out_valid    = r_hold_valid & ~stall_hazard;
    assign w_issue      = out_valid & out_ready;
    assign in_ready     = ~r_hold_valid | w_issue | flush;
    assign w_capture    = in_valid & in_ready & ~flush;
    assign w_load_issue = w_issue & (w_class == CLS_LOAD);

    // Flush wins over capture; an instruction offered alongside flush is consumed and dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_valid <= 1'b0;
            r_hold_instr <= '0;
            r_hold_pc    <= '0;
        end else begin
            if (flush) begin
                r_hold_valid <= 1'b0;
            end else if (w_capture) begin
                r_hold_valid <= 1'b1;
            end else if (w_issue) begin
                r_hold_valid <= 1'b0;
            end
            if (w_capture) begin
                r_hold_instr <= in_instr;
                r_hold_pc    <= in_pc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hazard_cycles <= '0;
        end else if (stall_hazard && (r_hazard_cycles != '1)) begin
            r_hazard_cycles <= r_hazard_cycles + CNT_W'(1);
        end
    end

    load_scoreboard #(
        .LOAD_LAT (LOAD_LAT)
    ) u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .i_load_issue (w_load_issue),
        .i_load_dst   (r_hold_instr[DST_LSB +: REG_W]),
        .i_src1_en    (w_src1_en),
        .i_src1       (r_hold_instr[SRC1_LSB +: REG_W]),
        .i_src2_en    (w_src2_en),
        .i_src2       (r_hold_instr[SRC2_LSB +: REG_W]),
        .o_hit        (w_hit)
    );

    assign w_brn_raw = {r_hold_instr[DST_LSB +: REG_W], r_hold_instr[BOFF_LO_MSB:0]};

    assign out_pc         = r_hold_pc;
    assign out_opcode     = w_opcode;
    assign out_dst_reg    = r_hold_instr[DST_LSB +: REG_W];
    assign out_src_reg_1  = r_hold_instr[SRC1_LSB +: REG_W];
    assign out_src_reg_2  = r_hold_instr[SRC2_LSB +: REG_W];
    assign out_mem_offset = {{(XLEN-15){r_hold_instr[MOFF_MSB]}}, r_hold_instr[MOFF_MSB:0]};
    assign out_brn_offset = {{(XLEN-17){w_brn_raw[14]}}, w_brn_raw, 2'b00};
    assign out_jmp_offset = {r_hold_instr[DST_LSB +: REG_W], r_hold_instr[MOFF_MSB:0]};

    assign out_mem_read    = out_valid & w_flags[FLAG_MEM_READ];
    assign out_mem_write   = out_valid & w_flags[FLAG_MEM_WRITE];
    assign out_mem_byte    = out_valid & w_flags[FLAG_MEM_BYTE];
    assign out_reg_write   = out_valid & w_flags[FLAG_REG_WRITE];
    assign out_mem_to_reg  = out_valid & w_flags[FLAG_MEM_TO_REG];
    assign out_alu_imm_src = out_mem_read | out_mem_write;
    assign out_branch      = out_valid & (w_class == CLS_BRANCH);
    assign out_jump        = out_valid & (w_class == CLS_JUMP);

    assign hazard_cycles = r_hazard_cycles;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic
// checked against a timestamp-based behavioural model of slot and load latency.
module tb_decode_stage;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_ready;

    logic        in_ready, out_valid, stall_hazard;
    logic [31:0] out_pc, out_mem_offset, out_brn_offset;
    logic [6:0]  out_opcode;
    logic [4:0]  out_dst_reg, out_src_reg_1, out_src_reg_2;
    logic [19:0] out_jmp_offset;
    logic        out_alu_imm_src, out_mem_read, out_mem_write, out_mem_byte;
    logic        out_reg_write, out_mem_to_reg, out_branch, out_jump;
    logic [15:0] hazard_cycles;

    logic        in_ready_s, out_valid_s, stall_hazard_s;
    logic [31:0] out_pc_s, out_mem_offset_s, out_brn_offset_s;
    logic [6:0]  out_opcode_s;
    logic [4:0]  out_dst_reg_s, out_src_reg_1_s, out_src_reg_2_s;
    logic [19:0] out_jmp_offset_s;
    logic        out_alu_imm_src_s, out_mem_read_s, out_mem_write_s, out_mem_byte_s;
    logic        out_reg_write_s, out_mem_to_reg_s, out_branch_s, out_jump_s;
    logic [1:0]  hazard_cycles_s;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: slot contents plus, per register, the last cycle it is busy
    bit          m_hv;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    int          m_busy [32];
    int          m_cnt;
    int          cyc = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .LOAD_LAT(LAT), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_opcode(out_opcode),
        .out_dst_reg(out_dst_reg), .out_src_reg_1(out_src_reg_1), .out_src_reg_2(out_src_reg_2),
        .out_mem_offset(out_mem_offset), .out_brn_offset(out_brn_offset),
        .out_jmp_offset(out_jmp_offset), .out_alu_imm_src(out_alu_imm_src),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_mem_byte(out_mem_byte),
        .out_reg_write(out_reg_write), .out_mem_to_reg(out_mem_to_reg),
        .out_branch(out_branch), .out_jump(out_jump), .stall_hazard(stall_hazard),
        .hazard_cycles(hazard_cycles)
    );

    decode_stage #(.XLEN(32), .LOAD_LAT(LAT), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_pc(out_pc_s), .out_opcode(out_opcode_s),
        .out_dst_reg(out_dst_reg_s), .out_src_reg_1(out_src_reg_1_s), .out_src_reg_2(out_src_reg_2_s),
        .out_mem_offset(out_mem_offset_s), .out_brn_offset(out_brn_offset_s),
        .out_jmp_offset(out_jmp_offset_s), .out_alu_imm_src(out_alu_imm_src_s),
        .out_mem_read(out_mem_read_s), .out_mem_write(out_mem_write_s), .out_mem_byte(out_mem_byte_s),
        .out_reg_write(out_reg_write_s), .out_mem_to_reg(out_mem_to_reg_s),
        .out_branch(out_branch_s), .out_jump(out_jump_s), .stall_hazard(stall_hazard_s),
        .hazard_cycles(hazard_cycles_s)
    );

    function automatic bit busy(input logic [4:0] r);
        return (r != 5'd0) && (cyc <= m_busy[r]);
    endfunction

    function automatic bit exp_stall();
        logic [6:0] op;
        bit alu, ld, sto, beq;
        op  = m_instr[31:25];
        alu = (op == 7'h00) || (op == 7'h01) || (op == 7'h02);
        ld  = (op == 7'h10) || (op == 7'h11);
        sto = (op == 7'h12) || (op == 7'h13);
        beq = (op == 7'h30);
        return m_hv && (((alu || ld || sto || beq) && busy(m_instr[19:15])) ||
                        ((alu || sto || beq) && busy(m_instr[14:10])));
    endfunction

    function automatic logic [148:0] exp_core();
        logic [6:0]  op;
        logic [4:0]  f;
        logic [31:0] moff, boff;
        bit br, jp, st, ov, rdy;
        int b;
        op = m_instr[31:25];
        case (op)
            7'h00, 7'h01, 7'h02: f = 5'b00010;
            7'h10: f = 5'b10111;
            7'h11: f = 5'b10011;
            7'h12: f = 5'b01100;
            7'h13: f = 5'b01000;
            default: f = 5'b00000;
        endcase
        br  = (op == 7'h30);
        jp  = (op == 7'h31);
        st  = exp_stall();
        ov  = m_hv && !st;
        rdy = !m_hv || (ov && out_ready) || flush;
        if (!ov) begin
            f = 5'b0; br = 1'b0; jp = 1'b0;
        end
        moff = 32'($signed(m_instr[14:0]));
        b = int'({m_instr[24:20], m_instr[9:0]});
        if (b >= 16384) b -= 32768;
        boff = 32'(b * 4);
        return {ov, rdy, st, f[4] | f[3], f, br, jp, m_pc, op, m_instr[24:20], m_instr[19:15],
                m_instr[14:10], moff, boff, m_instr[24:20], m_instr[14:0]};
    endfunction

    function automatic logic [15:0] exp_cnt(input int w);
        int lim;
        lim = (1 << w) - 1;
        return 16'((m_cnt > lim) ? lim : m_cnt);
    endfunction

    function automatic logic [148:0] dut_core(input bit sat);
        if (sat)
            return {out_valid_s, in_ready_s, stall_hazard_s, out_alu_imm_src_s, out_mem_read_s,
                    out_mem_write_s, out_mem_byte_s, out_reg_write_s, out_mem_to_reg_s, out_branch_s,
                    out_jump_s, out_pc_s, out_opcode_s, out_dst_reg_s, out_src_reg_1_s, out_src_reg_2_s,
                    out_mem_offset_s, out_brn_offset_s, out_jmp_offset_s};
        return {out_valid, in_ready, stall_hazard, out_alu_imm_src, out_mem_read, out_mem_write,
                out_mem_byte, out_reg_write, out_mem_to_reg, out_branch, out_jump, out_pc, out_opcode,
                out_dst_reg, out_src_reg_1, out_src_reg_2, out_mem_offset, out_brn_offset, out_jmp_offset};
    endfunction

    task automatic model_reset();
        m_hv = 1'b0; m_instr = '0; m_pc = '0; m_cnt = 0;
        for (int i = 0; i < 32; i++) m_busy[i] = cyc - 1;
    endtask

    task automatic model_step();
        bit st, ov, rdy, iss;
        logic [6:0] op;
        st  = exp_stall();
        ov  = m_hv && !st;
        rdy = !m_hv || (ov && out_ready) || flush;
        iss = ov && out_ready;
        op  = m_instr[31:25];
        if (st) m_cnt++;
        if (iss && (op == 7'h10 || op == 7'h11) && m_instr[24:20] != 5'd0)
            m_busy[m_instr[24:20]] = cyc + LAT;
        if (flush) m_hv = 1'b0;
        else if (in_valid && rdy) begin
            m_hv = 1'b1; m_instr = in_instr; m_pc = in_pc;
        end else if (iss) m_hv = 1'b0;
        cyc++;
    endtask

    task automatic set_in(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                          input bit ordy, input bit fl);
        in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
        #1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] op;
        logic [4:0] s2;
        case ($urandom_range(0, 9))
            0: op = 7'h00; 1: op = 7'h01; 2: op = 7'h02;
            3: op = 7'h10; 4: op = 7'h11; 5: op = 7'h12; 6: op = 7'h13;
            7: op = 7'h30; 8: op = 7'h31;
            default: op = 7'($urandom_range(3, 127));
        endcase
        s2 = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
        return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), s2, 10'($urandom)};
    endfunction

    task automatic test_reset();
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || hazard_cycles !== 16'd0 || stall_hazard !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl got ov=%b ir=%b hc=%0d st=%b want ov=0 ir=1 hc=0 st=0",
                     out_valid, in_ready, hazard_cycles, stall_hazard);
        end
        n_vec++;
        if ({dut_core(0), hazard_cycles} !== {exp_core(), exp_cnt(16)}) begin
            n_err++;
            $display("FAIL reset_vec got=%h want=%h", {dut_core(0), hazard_cycles}, {exp_core(), exp_cnt(16)});
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        set_in(0, '0, '0, 1, 0);
        n_vec++;
        if ({dut_core(1), hazard_cycles_s} !== {exp_core(), 2'(exp_cnt(2))}) begin
            n_err++;
            $display("FAIL reset_after_release got=%h want=%h", {dut_core(1), hazard_cycles_s},
                     {exp_core(), 2'(exp_cnt(2))});
        end
    endtask

    task automatic test_offsets();
        set_in(1, 32'h22304000, 32'h100, 0, 0);
        tick();
        set_in(0, '0, '0, 0, 0);
        n_vec++;
        if (out_mem_offset !== 32'hFFFFC000) begin
            n_err++;
            $display("FAIL mem_offset got=%h want=ffffc000", out_mem_offset);
        end
        n_vec++;
        if ({out_mem_read, out_mem_write, out_mem_byte, out_reg_write, out_mem_to_reg, out_alu_imm_src} !== 6'b100111) begin
            n_err++;
            $display("FAIL ldw_flags got=%b want=100111",
                     {out_mem_read, out_mem_write, out_mem_byte, out_reg_write, out_mem_to_reg, out_alu_imm_src});
        end
        n_vec++;
        if (out_valid !== 1'b1 || out_dst_reg !== 5'd3 || out_src_reg_1 !== 5'd0 || out_pc !== 32'h100) begin
            n_err++;
            $display("FAIL ldw_fields got ov=%b dst=%0d s1=%0d pc=%h want ov=1 dst=3 s1=0 pc=100",
                     out_valid, out_dst_reg, out_src_reg_1, out_pc);
        end
        set_in(0, '0, '0, 1, 0);
        tick();
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_branch();
        set_in(1, 32'h61F003FF, 32'h180, 0, 0);
        tick();
        set_in(0, '0, '0, 0, 0);
        n_vec++;
        if (out_brn_offset !== 32'hFFFFFFFC || out_branch !== 1'b1 || out_reg_write !== 1'b0 || out_jump !== 1'b0) begin
            n_err++;
            $display("FAIL beq_decode got off=%h br=%b rw=%b jp=%b want off=fffffffc br=1 rw=0 jp=0",
                     out_brn_offset, out_branch, out_reg_write, out_jump);
        end
        n_vec++;
        if ({dut_core(0), hazard_cycles} !== {exp_core(), exp_cnt(16)}) begin
            n_err++;
            $display("FAIL beq_vec got=%h want=%h", {dut_core(0), hazard_cycles}, {exp_core(), exp_cnt(16)});
        end
        set_in(0, '0, '0, 1, 0);
        tick();
        tick();
    endtask

    task automatic test_load_use(input logic [31:0] ld_instr, input int stalls);
        logic [15:0] want_hc;
        want_hc = 16'(m_cnt + stalls);
        set_in(1, ld_instr, 32'h200, 1, 0);
        tick();
        set_in(1, 32'h00418800, 32'h204, 1, 0);
        n_vec++;
        if (out_valid !== 1'b1 || out_opcode !== 7'h11 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL load_present got ov=%b op=%h ir=%b want ov=1 op=11 ir=1", out_valid, out_opcode, in_ready);
        end
        tick();
        set_in(0, '0, '0, 1, 0);
        for (int k = 0; k < stalls; k++) begin
            n_vec++;
            if (stall_hazard !== 1'b1 || out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL load_use_stall%0d got st=%b ov=%b want st=1 ov=0", k, stall_hazard, out_valid);
            end
            tick();
        end
        n_vec++;
        if (stall_hazard !== 1'b0 || out_valid !== 1'b1 || out_opcode !== 7'h00 || out_dst_reg !== 5'd4 ||
            hazard_cycles !== want_hc) begin
            n_err++;
            $display("FAIL load_use_issue got st=%b ov=%b op=%h dst=%0d hc=%0d want st=0 ov=1 op=0 dst=4 hc=%0d",
                     stall_hazard, out_valid, out_opcode, out_dst_reg, hazard_cycles, want_hc);
        end
        tick();
        tick();
    endtask

    task automatic test_backpressure_flush();
        set_in(1, 32'h00418800, 32'h300, 0, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            set_in(1, 32'h02000000, 32'h304, 0, 0);
            n_vec++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h300 || out_dst_reg !== 5'd4 ||
                out_reg_write !== 1'b1) begin
                n_err++;
                $display("FAIL backpressure%0d got ir=%b ov=%b pc=%h dst=%0d rw=%b want ir=0 ov=1 pc=300 dst=4 rw=1",
                         k, in_ready, out_valid, out_pc, out_dst_reg, out_reg_write);
            end
            tick();
        end
        set_in(1, 32'h02000000, 32'h304, 0, 1);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_ready got=%b want=1", in_ready);
        end
        tick();
        set_in(0, '0, '0, 1, 0);
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (out_valid !== 1'b0 || out_reg_write !== 1'b0) begin
                n_err++;
                $display("FAIL flush_drop%0d got ov=%b rw=%b want ov=0 rw=0", k, out_valid, out_reg_write);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [4];
        for (int i = 0; i < 4; i++)
            ins[i] = {7'(i % 3), 5'($urandom_range(1, 31)), 5'd0, 5'd0, 10'($urandom)};
        for (int i = 0; i < 5; i++) begin
            if (i < 4) set_in(1, ins[i], 32'h400 + 32'(4 * i), 1, 0);
            else       set_in(0, '0, '0, 1, 0);
            if (i > 0) begin
                n_vec++;
                if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_pc !== 32'h400 + 32'(4 * (i - 1)) ||
                    out_opcode !== ins[i-1][31:25]) begin
                    n_err++;
                    $display("FAIL back_to_back%0d got ov=%b ir=%b pc=%h op=%h want ov=1 ir=1 pc=%h op=%h",
                             i, out_valid, in_ready, out_pc, out_opcode, 32'h400 + 32'(4 * (i - 1)), ins[i-1][31:25]);
                end
            end
            tick();
        end
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            set_in($urandom_range(0, 99) < 70, rand_instr(), $urandom,
                   $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 5);
            n_vec++;
            if ({dut_core(0), hazard_cycles} !== {exp_core(), exp_cnt(16)}) begin
                n_err++;
                $display("FAIL random_main cyc=%0d got=%h want=%h", cyc, {dut_core(0), hazard_cycles},
                         {exp_core(), exp_cnt(16)});
            end
            n_vec++;
            if ({dut_core(1), hazard_cycles_s} !== {exp_core(), 2'(exp_cnt(2))}) begin
                n_err++;
                $display("FAIL random_sat cyc=%0d got=%h want=%h", cyc, {dut_core(1), hazard_cycles_s},
                         {exp_core(), 2'(exp_cnt(2))});
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_stall();
        set_in(0, '0, '0, 1, 1);
        tick();
        set_in(0, '0, '0, 1, 0);
        for (int i = 0; i < 4; i++) tick();
        set_in(1, 32'h22308008, 32'h500, 1, 0);
        tick();
        set_in(1, 32'h00418800, 32'h504, 1, 0);
        tick();
        set_in(0, '0, '0, 1, 0);
        n_vec++;
        if (stall_hazard !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_stall got=%b want=1", stall_hazard);
        end
        #2 reset = 1'b1;
        model_reset();
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || stall_hazard !== 1'b0 || hazard_cycles !== 16'd0 ||
            hazard_cycles_s !== 2'd0) begin
            n_err++;
            $display("FAIL mid_stall_reset got ov=%b ir=%b st=%b hc=%0d hcs=%0d want 0 1 0 0 0",
                     out_valid, in_ready, stall_hazard, hazard_cycles, hazard_cycles_s);
        end
        #1 reset = 1'b0;
        tick();
        n_vec++;
        if ({dut_core(0), hazard_cycles} !== {exp_core(), exp_cnt(16)}) begin
            n_err++;
            $display("FAIL post_reset_vec got=%h want=%h", {dut_core(0), hazard_cycles}, {exp_core(), exp_cnt(16)});
        end
    endtask

    task automatic test_saturation();
        logic [31:0] prog [7];
        int idx;
        int budget;
        prog = '{32'h22308008, 32'h00418800, 32'h22308008, 32'hFE000000,
                 32'h00418800, 32'h22308008, 32'h00418800};
        idx = 0;
        budget = 0;
        while (idx < 7 && budget < 100) begin
            set_in(1, prog[idx], 32'h600 + 32'(4 * idx), 1, 0);
            if (in_ready === 1'b1) idx++;
            tick();
            budget++;
        end
        if (idx < 7) begin
            n_vec++;
            n_err++;
            $display("FAIL sat_program_timeout got accepted=%0d want=7", idx);
        end
        set_in(0, '0, '0, 1, 0);
        for (int i = 0; i < 6; i++) tick();
        n_vec++;
        if (hazard_cycles !== 16'd5) begin
            n_err++;
            $display("FAIL sat_main_count got=%0d want=5", hazard_cycles);
        end
        n_vec++;
        if (hazard_cycles_s !== 2'd3) begin
            n_err++;
            $display("FAIL sat_narrow_count got=%0d want=3", hazard_cycles_s);
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
        model_reset();
        #2;
        test_reset();
        test_offsets();
        test_branch();
        test_load_use(32'h22308008, 2);
        test_load_use(32'h22008008, 0);
        test_backpressure_flush();
        test_back_to_back();
        test_random(400);
        test_reset_mid_stall();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
